pid_ctrl_param: RTL and testbench

Parametrised PID controller for the pedal-assist motor drive. It converts a signed torque/cadence error into an unsigned drive magnitude for the brushless commutation/PWM stage. Width, gain shifts, decimation period and derivative history depth are parameters. It adds an input-valid capture, a registered two-stage output pipeline with an update strobe, and an optional integrator anti-windup.

---
 rtl/pid_pkg.sv | 30 +++
 rtl/sat_signed.sv | 49 ++++
 rtl/pid_ctrl_param.sv | 126 ++++++++++++
 tb/tb_pid_ctrl_param.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared defaults, sum-width helper and saturation tags for the pedal-assist PID controller.
package pid_pkg;

  localparam int ERR_W_DEF       = 13;
  localparam int DRV_W_DEF       = 12;
  localparam int INT_W_DEF       = 18;
  localparam int DEC_W_DEF       = 20;
  localparam int D_DEPTH_DEF     = 3;
  localparam int KP_SHIFT_DEF    = 0;
  localparam int KI_SHIFT_DEF    = 5;
  localparam int KD_SHIFT_DEF    = 2;
  localparam int D_SAT_W_DEF     = 9;
  localparam int FAST_SIM_TICK_W = 15;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_HI   = 2'd1,
    SAT_LO   = 2'd2
  } sat_sel_e;

  // Two guard bits above the widest term so P+I+D can never wrap.
  function automatic int sum_w_f(input int p_w, input int i_w, input int d_w);
    int m;
    m = p_w;
    if (i_w > m) m = i_w;
    if (d_w > m) m = d_w;
    return m + 2;
  endfunction

endpackage

// File: rtl/sat_signed.sv
// Combinational clamp of a signed value into a narrower signed or unsigned range.
module sat_signed
  import pid_pkg::*;
#(
  parameter int IN_W         = 14,
  parameter int OUT_W        = 9,
  parameter bit UNSIGNED_OUT = 1'b0
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o,
  output sat_sel_e         sat_o
);

  localparam int SH = UNSIGNED_OUT ? OUT_W : OUT_W - 1;

  logic signed [IN_W-1:0] in_s;
  logic signed [IN_W-1:0] top_s;

  assign in_s  = $signed(in_i);
  // Bits above the representable range; in range means they are all sign copies.
  assign top_s = in_s >>> SH;

  if (UNSIGNED_OUT) begin : g_uns
    always_comb begin
      out_o = in_i[OUT_W-1:0];
      sat_o = SAT_NONE;
      if (in_s < 0) begin
        out_o = '0;
        sat_o = SAT_LO;
      end else if (top_s != 0) begin
        out_o = '1;
        sat_o = SAT_HI;
      end
    end
  end else begin : g_sgn
    always_comb begin
      out_o = in_i[OUT_W-1:0];
      sat_o = SAT_NONE;
      if (top_s > 0) begin
        out_o = {1'b0, {(OUT_W-1){1'b1}}};
        sat_o = SAT_HI;
      end else if (top_s < -1) begin
        out_o = {1'b1, {(OUT_W-1){1'b0}}};
        sat_o = SAT_LO;
      end
    end
  end

endmodule

// File: rtl/pid_ctrl_param.sv
// PID controller: error capture, decimated integrator/derivative update, two-stage output.
// Define PID_ANTIWINDUP_EN to freeze the integrator while the output is saturated in the error's direction.
module pid_ctrl_param
  import pid_pkg::*;
#(
  parameter int ERR_W    = ERR_W_DEF,
  parameter int DRV_W    = DRV_W_DEF,
  parameter int INT_W    = INT_W_DEF,
  parameter int DEC_W    = DEC_W_DEF,
  parameter int FAST_SIM = 0,
  parameter int D_DEPTH  = D_DEPTH_DEF,
  parameter int KP_SHIFT = KP_SHIFT_DEF,
  parameter int KI_SHIFT = KI_SHIFT_DEF,
  parameter int KD_SHIFT = KD_SHIFT_DEF,
  parameter int D_SAT_W  = D_SAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             not_pedaling,
  input  logic             err_vld,
  input  logic [ERR_W-1:0] error,
  output logic [DRV_W-1:0] drv_mag,
  output logic             drv_vld
);

  localparam int P_W    = ERR_W + KP_SHIFT;
  localparam int D_W    = D_SAT_W + KD_SHIFT;
  localparam int SUM_W  = sum_w_f(P_W, INT_W, D_W);
  localparam int TICK_W = (FAST_SIM != 0 && DEC_W > FAST_SIM_TICK_W) ? FAST_SIM_TICK_W : DEC_W;
  localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};

  logic [ERR_W-1:0]              err_q;
  logic [DEC_W-1:0]              dec_q;
  logic [INT_W-1:0]              integ_q, integ_d;
  logic [D_DEPTH-1:0][ERR_W-1:0] hist_q;
  logic [SUM_W-1:0]              p_q, i_q, d_q;
  logic [DRV_W-1:0]              drv_mag_q, drv_mag_d;
  logic                          tick_q1, tick_q2, drv_vld_q;

  logic             tick;
  logic [INT_W:0]   int_sum;
  logic [ERR_W:0]   d_diff;
  logic [D_SAT_W-1:0] d_clamped;
  logic [INT_W-1:0] i_shift;
  logic [SUM_W-1:0] p_d, i_d, d_d, s_d;
  logic             aw_hold;
  sat_sel_e         out_sat, d_sat_unused;

  assign tick    = &dec_q[TICK_W-1:0];
  assign int_sum = {integ_q[INT_W-1], integ_q} + {{(INT_W+1-ERR_W){err_q[ERR_W-1]}}, err_q};
  assign d_diff  = {err_q[ERR_W-1], err_q} - {hist_q[D_DEPTH-1][ERR_W-1], hist_q[D_DEPTH-1]};

  sat_signed #(.IN_W(ERR_W + 1), .OUT_W(D_SAT_W), .UNSIGNED_OUT(1'b0)) u_d_sat (
    .in_i (d_diff),
    .out_o(d_clamped),
    .sat_o(d_sat_unused)
  );

  assign p_d     = {{(SUM_W-ERR_W){err_q[ERR_W-1]}}, err_q} << KP_SHIFT;
  assign i_shift = $signed(integ_q) >>> KI_SHIFT;
  assign i_d     = {{(SUM_W-INT_W){i_shift[INT_W-1]}}, i_shift};
  assign d_d     = {{(SUM_W-D_SAT_W){d_clamped[D_SAT_W-1]}}, d_clamped} << KD_SHIFT;
  assign s_d     = p_q + i_q + d_q;

  sat_signed #(.IN_W(SUM_W), .OUT_W(DRV_W), .UNSIGNED_OUT(1'b1)) u_out_sat (
    .in_i (s_d),
    .out_o(drv_mag_d),
    .sat_o(out_sat)
  );

`ifdef PID_ANTIWINDUP_EN
  assign aw_hold = ((out_sat == SAT_HI) && !err_q[ERR_W-1] && (err_q != '0)) ||
                   ((out_sat == SAT_LO) && err_q[ERR_W-1]);
`else
  logic out_sat_unused;
  assign out_sat_unused = (out_sat != SAT_NONE);
  assign aw_hold        = 1'b0;
`endif

  // Integrator is kept non-negative: negative sums floor at zero.
  always_comb begin
    integ_d = integ_q;
    if (not_pedaling) begin
      integ_d = '0;
    end else if (tick && !aw_hold) begin
      if (int_sum[INT_W])        integ_d = '0;
      else if (int_sum[INT_W-1]) integ_d = INT_MAX;
      else                       integ_d = int_sum[INT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= '0;
      dec_q     <= '0;
      integ_q   <= '0;
      hist_q    <= '0;
      p_q       <= '0;
      i_q       <= '0;
      d_q       <= '0;
      drv_mag_q <= '0;
      tick_q1   <= 1'b0;
      tick_q2   <= 1'b0;
      drv_vld_q <= 1'b0;
    end else begin
      if (err_vld) err_q <= error;
      dec_q   <= dec_q + DEC_W'(1);
      integ_q <= integ_d;
      if (tick) begin
        hist_q[0] <= err_q;
        for (int k = 1; k < D_DEPTH; k++) hist_q[k] <= hist_q[k-1];
      end
      p_q       <= p_d;
      i_q       <= i_d;
      d_q       <= d_d;
      drv_mag_q <= drv_mag_d;
      tick_q1   <= tick;
      tick_q2   <= tick_q1;
      drv_vld_q <= tick_q2;
    end
  end

  assign drv_mag = drv_mag_q;
  assign drv_vld = drv_vld_q;

endmodule

// File: tb/tb_pid_ctrl_param.sv
// Bench for pid_ctrl_param: vector table per tick plus hand sequences; short decimator period.
module tb_pid_ctrl_param;

  localparam int ERR_W = 13;
  localparam int DRV_W = 12;
  localparam int INT_W = 18;
  localparam int DEC_W = 6;
  localparam int NVEC  = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             not_pedaling = 1'b0;
  logic             err_vld = 1'b1;
  logic [ERR_W-1:0] error = 13'h0100;
  logic [DRV_W-1:0] drv_mag;
  logic             drv_vld;

  int total = 0;
  int bad = 0;
  int strobes = 0;
  int exp_q[$];
  int exp_v;

  typedef struct {
    bit np;
    bit vld;
    int err;
    int exp_drv;
    int exp_aw;
  } vec_t;
  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  pid_ctrl_param #(
    .ERR_W(ERR_W), .DRV_W(DRV_W), .INT_W(INT_W), .DEC_W(DEC_W), .FAST_SIM(0),
    .D_DEPTH(3), .KP_SHIFT(0), .KI_SHIFT(5), .KD_SHIFT(2), .D_SAT_W(9)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .not_pedaling(not_pedaling),
    .err_vld(err_vld),
    .error(error),
    .drv_mag(drv_mag),
    .drv_vld(drv_vld)
  );

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every drv_vld strobe consumes the oldest expected magnitude.
  always @(negedge clk) begin
    if (rst_n && drv_vld) begin
      strobes++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", drv_mag, -1);
      end else begin
        exp_v = exp_q.pop_front();
        $display("txn %0d: drv_mag=%0d expected=%0d", strobes, drv_mag, exp_v);
        check("drv_mag", drv_mag, exp_v);
      end
    end
  end

  task automatic wait_strobes(input int n);
    int target = strobes + n;
    int budget = n * 70 + 100;
    while (strobes < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("strobe_wait", strobes, target);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    err_vld = 1'b0;
    not_pedaling = 1'b0;
    error = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_err(input logic [ERR_W-1:0] v);
    error = v;
    err_vld = 1'b1;
    @(negedge clk);
    err_vld = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int n;
    // {np, vld, err, expected drv, expected drv with anti-windup}
    vecs[0]  = '{0, 0, 0,    1284, 1284};
    vecs[1]  = '{0, 0, 0,    1292, 1292};
    vecs[2]  = '{0, 0, 0,    280,  280};
    vecs[3]  = '{0, 1, -256, 0,    0};
    vecs[4]  = '{0, 0, 0,    0,    0};
    vecs[5]  = '{0, 0, 0,    0,    0};
    vecs[6]  = '{0, 0, 0,    0,    0};
    vecs[7]  = '{0, 1, 100,  1123, 1147};
    vecs[8]  = '{0, 0, 0,    1126, 1150};
    vecs[9]  = '{0, 0, 0,    109,  133};
    vecs[10] = '{1, 0, 0,    100,  100};
    vecs[11] = '{1, 0, 0,    100,  100};
    vecs[12] = '{0, 0, 0,    103,  103};
    vecs[13] = '{0, 1, -20,  0,    0};
    vecs[14] = '{0, 0, 0,    0,    0};
    vecs[15] = '{0, 0, 0,    0,    0};
    vecs[16] = '{0, 1, 50,   332,  334};
    vecs[17] = '{0, 1, 2000, 3085, 3087};
    vecs[18] = '{0, 0, 0,    3147, 3149};
    vecs[19] = '{0, 0, 0,    2190, 2192};

    // Reset held with a valid error on the input
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_drv_mag", drv_mag, 0);
      check("reset_drv_vld", drv_vld, 0);
    end
    err_vld = 1'b0;
    rst_n = 1'b1;

    // Single error pulse: three-cycle latency to drv_mag
    @(negedge clk);
    load_err(13'h0100);
    @(negedge clk);
    check("latency_early", drv_mag, 0);
    @(negedge clk);
    check("latency_p_plus_d", drv_mag, 1276);

    // Per-tick vector table
    for (int r = 0; r < NVEC; r++) begin
      not_pedaling = vecs[r].np;
`ifdef PID_ANTIWINDUP_EN
      exp_q.push_back(vecs[r].exp_aw);
`else
      exp_q.push_back(vecs[r].exp_drv);
`endif
      if (vecs[r].vld) load_err(ERR_W'(vecs[r].err));
      if (vecs[r].np) begin
        @(negedge clk);
        check("integ_cleared", dut.integ_q, 0);
      end
      wait_strobes(1);
    end
    not_pedaling = 1'b0;

    // err_vld coinciding with tick: integrator and history see the old err_q
    do_reset();
    guard = 0;
    while (!dut.tick && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("tick_found", dut.tick, 1);
    exp_q.push_back(1320);
    exp_q.push_back(1329);
    exp_q.push_back(1338);
    exp_q.push_back(328);
    load_err(13'd300);
    wait_strobes(4);

    // Negative error held: integrator floors at zero
    do_reset();
    load_err(13'h1F00);
    for (int i = 0; i < 10; i++) exp_q.push_back(0);
    wait_strobes(10);
    check("neg_integ", dut.integ_q, 0);

    // Large positive error: integrator clamp (or freeze under anti-windup)
    do_reset();
    load_err(13'h0FFF);
    for (int i = 0; i < 32; i++) exp_q.push_back(4095);
    wait_strobes(32);
`ifdef PID_ANTIWINDUP_EN
    check("integ_tick32", dut.integ_q, 0);
`else
    check("integ_tick32", dut.integ_q, 131040);
`endif
    exp_q.push_back(4095);
    wait_strobes(1);
`ifdef PID_ANTIWINDUP_EN
    check("integ_tick33", dut.integ_q, 0);
`else
    check("integ_tick33", dut.integ_q, 131071);
`endif

    // Asynchronous reset mid-run
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_drv_mag", drv_mag, 0);
    check("async_drv_vld", drv_vld, 0);
    check("async_dec", dut.dec_q, 0);
    check("async_integ", dut.integ_q, 0);
    exp_q.delete();
    @(negedge clk);
    exp_q.push_back(0);
    rst_n = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (drv_vld) break;
    end
    check("restart_cycles", n, 66);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
